ft245_tx_arbiter: RTL and testbench

- Shares the single 64-bit write port of the ft245 TX FIFO (wren/wrdata/wrfifo_full) between NUM_REQ on-chip requesters.
- Arbitrates round-robin at packet granularity; wraps each packet in a header word and a trailer word so the PC side can demultiplex the byte stream.
- Sits in the clk_40mhz domain between the acquisition/telemetry sources and ft245.

---
 rtl/ft245_tx_arbiter_pkg.sv | 41 ++++
 rtl/ft245_tx_arbiter_if.sv | 25 ++
 rtl/ft245_tx_arbiter_rr.sv | 29 ++
 rtl/ft245_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_ft245_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ft245_tx_arbiter_pkg.sv
// rtl/ft245_tx_arbiter_pkg.sv - framing constants, FSM states and word builders for the ft245 TX arbiter
package ft245_tx_arbiter_pkg;

    localparam logic [7:0] SYNC_HDR = 8'hA5;
    localparam logic [7:0] SYNC_TRL = 8'h5A;

    // Field positions shared by header and trailer words
    localparam int F_SYNC_LSB  = 56;
    localparam int F_CH_LSB    = 48;
    localparam int F_SEQ_LSB   = 32;
    localparam int F_TRUNC_BIT = 31;
    localparam int F_CNT_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        TRAILER = 2'd2
    } state_t;

    function automatic logic [63:0] make_header(input logic [7:0] ch, input logic [15:0] seq);
        logic [63:0] w;
        w = '0;
        w[F_SYNC_LSB +: 8] = SYNC_HDR;
        w[F_CH_LSB +: 8]   = ch;
        w[F_SEQ_LSB +: 16] = seq;
        return w;
    endfunction

    function automatic logic [63:0] make_trailer(input logic [7:0] ch, input logic [15:0] seq,
                                                 input logic trunc, input logic [15:0] cnt);
        logic [63:0] w;
        w = '0;
        w[F_SYNC_LSB +: 8]  = SYNC_TRL;
        w[F_CH_LSB +: 8]    = ch;
        w[F_SEQ_LSB +: 16]  = seq;
        w[F_TRUNC_BIT]      = trunc;
        w[F_CNT_LSB +: 16]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/ft245_tx_arbiter_if.sv
// rtl/ft245_tx_arbiter_if.sv - requester bus and ft245 write port bundle
interface ft245_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wren;
    logic [DATA_WIDTH-1:0]         wrdata;
    logic                          wrfifo_full;

    // Arbiter side: drives the ft245 write port and the per-channel accepts
    modport master (
        input  req_valid, req_data, req_last, wrfifo_full,
        output req_ready, wren, wrdata
    );

    // Requester / ft245 side
    modport slave (
        output req_valid, req_data, req_last, wrfifo_full,
        input  req_ready, wren, wrdata
    );
endinterface

// File: rtl/ft245_tx_arbiter_rr.sv
// rtl/ft245_tx_arbiter_rr.sv - combinational round-robin picker starting after the last grant
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic found;
    int   c;

    // Scan channels last+1 .. last+N (mod N); the first requester wins
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 1; i <= N; i++) begin
            c = (int'(last) + i) % N;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end
endmodule

// File: rtl/ft245_tx_arbiter.sv
// rtl/ft245_tx_arbiter.sv - packet-level round-robin sharing of the ft245 TX write port
module ft245_tx_arbiter
    import ft245_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    ft245_tx_arbiter_if.master  bus,
    output logic                busy,
    output logic [7:0]          active_ch
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                      state_q, state_d;
    logic [IW-1:0]               grant_q, grant_d;
    logic [IW-1:0]               rr_q, rr_d;
    logic                        hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]       hold_data_q, hold_data_d;
    logic [NUM_REQ-1:0][15:0]    seq_q, seq_d;
    logic [15:0]                 count_q, count_d;
    logic                        trunc_q, trunc_d;

    logic [NUM_REQ-1:0]          rr_grant_oh;
    logic [IW-1:0]               rr_idx;
    logic [NUM_REQ-1:0]          req_ready_w;
    logic                        wren_w;
    logic                        can_accept;
    logic                        cur_valid;
    logic                        cur_last;
    logic [DATA_WIDTH-1:0]       cur_data;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req   (bus.req_valid),
        .last  (rr_q),
        .grant (rr_grant_oh),
        .idx   (rr_idx)
    );

    assign wren_w        = hold_valid_q & ~bus.wrfifo_full;
    assign can_accept    = ~hold_valid_q | wren_w;
    assign cur_valid     = bus.req_valid[grant_q];
    assign cur_last      = bus.req_last[grant_q];
    assign cur_data      = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

    assign bus.wren      = wren_w;
    assign bus.wrdata    = hold_data_q;
    assign bus.req_ready = req_ready_w;
    assign busy          = (state_q != IDLE) | hold_valid_q;
    assign active_ch     = (state_q == IDLE) ? 8'd0 : 8'(grant_q);

    // Next-state, hold-stage loading and per-channel ready generation
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        hold_valid_d = hold_valid_q & ~wren_w;
        hold_data_d  = hold_data_q;
        seq_d        = seq_q;
        count_d      = count_q;
        trunc_d      = trunc_q;
        req_ready_w  = '0;
        unique case (state_q)
            IDLE: begin
                if ((|rr_grant_oh) && can_accept) begin
                    grant_d      = rr_idx;
                    rr_d         = rr_idx;
                    hold_valid_d = 1'b1;
                    hold_data_d  = make_header(8'(rr_idx), seq_q[rr_idx]);
                    state_d      = DATA;
                end
            end
            DATA: begin
                req_ready_w[grant_q] = can_accept;
                if (can_accept && cur_valid) begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = cur_data;
                    count_d      = count_q + 16'd1;
                    // A last word that lands exactly on the burst limit still ends a whole packet
                    if (cur_last || (count_q + 16'd1 == 16'(MAX_BURST))) begin
                        trunc_d = ~cur_last;
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                if (can_accept) begin
                    hold_valid_d   = 1'b1;
                    hold_data_d    = make_trailer(8'(grant_q), seq_q[grant_q], trunc_q, count_q);
                    seq_d[grant_q] = seq_q[grant_q] + 16'd1;
                    count_d        = '0;
                    trunc_d        = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_q         <= IW'(NUM_REQ - 1);
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            seq_q        <= '0;
            count_q      <= '0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            seq_q        <= seq_d;
            count_q      <= count_d;
            trunc_q      <= trunc_d;
        end
    end
endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// tb/tb_ft245_tx_arbiter.sv - directed self-checking bench for ft245_tx_arbiter
module tb_ft245_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [7:0] active_ch;

    ft245_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(64)) bus ();

    ft245_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .active_ch (active_ch)
    );

    always #5 clk = ~clk;

    int          vecs = 0;
    int          miss = 0;
    int          cyc = 0;
    logic [64:0] chq [4][$];
    logic [63:0] outq[$];
    logic [63:0] expq[$];
    int          outc[$];
    logic        s_wren;
    logic        s_busy;
    logic [3:0]  s_ready;
    logic [63:0] s_wrdata;
    logic [7:0]  s_active;

    function automatic logic [63:0] hdr(input int ch, input logic [15:0] seq);
        return {8'hA5, 8'(ch), seq, 32'h0};
    endfunction

    function automatic logic [63:0] trl(input int ch, input logic [15:0] seq, input logic tr, input logic [15:0] cnt);
        return {8'h5A, 8'(ch), seq, tr, 15'h0, cnt};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [64:0] e;
        for (int c = 0; c < 4; c++) begin
            if (chq[c].size() > 0) begin
                e = chq[c][0];
                bus.req_valid[c]        = 1'b1;
                bus.req_data[c*64 +: 64] = e[63:0];
                bus.req_last[c]         = e[64];
            end else begin
                bus.req_valid[c]        = 1'b0;
                bus.req_data[c*64 +: 64] = '0;
                bus.req_last[c]         = 1'b0;
            end
        end
    endtask

    task automatic push(input int ch, input logic [63:0] d, input logic last);
        chq[ch].push_back({last, d});
    endtask

    function automatic bit all_empty();
        return (chq[0].size() == 0) && (chq[1].size() == 0) && (chq[2].size() == 0) && (chq[3].size() == 0);
    endfunction

    task automatic tick();
        logic [3:0] fire;
        @(negedge clk);
        s_wren   = bus.wren;
        s_wrdata = bus.wrdata;
        s_ready  = bus.req_ready;
        s_busy   = busy;
        s_active = active_ch;
        fire     = bus.req_valid & bus.req_ready;
        if (bus.wren) begin
            outq.push_back(bus.wrdata);
            outc.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        #2;
        for (int c = 0; c < 4; c++)
            if (fire[c] && chq[c].size() > 0) void'(chq[c].pop_front());
        drive();
    endtask

    task automatic run(input string tag, input int max);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < max) begin
            tick();
            n++;
            done = !s_busy && all_empty();
        end
        chk({tag, " completed"}, 64'(done), 64'd1);
    endtask

    task automatic cmp(input string tag);
        logic [63:0] o;
        chk({tag, " count"}, 64'(outq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            o = (i < outq.size()) ? outq[i] : 64'hDEAD_DEAD_DEAD_DEAD;
            chk($sformatf("%s[%0d]", tag, i), o, expq[i]);
        end
        outq.delete();
        expq.delete();
        outc.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.req_last    = '0;
        bus.wrfifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset wren", 64'(bus.wren), 64'd0);
        chk("reset wrdata", bus.wrdata, 64'd0);
        chk("reset req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset active_ch", 64'(active_ch), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single 3-word packet on ch0, timing from first valid
        push(0, 64'hD000_0000_0000_00D0, 1'b0);
        push(0, 64'hD111_0000_0000_00D1, 1'b0);
        push(0, 64'hD222_0000_0000_00D2, 1'b1);
        cyc = 0;
        drive();
        run("single", 40);
        chk("single first wren cycle", 64'((outc.size() > 0) ? outc[0] : -1), 64'd1);
        chk("single last wren cycle", 64'((outc.size() > 4) ? outc[4] : -1), 64'd5);
        expq = '{64'hA500_0000_0000_0000, 64'hD000_0000_0000_00D0, 64'hD111_0000_0000_00D1,
                 64'hD222_0000_0000_00D2, 64'h5A00_0000_0000_0003};
        cmp("single");

        // Sequence wrap on ch0
        force dut.seq_q = 64'h0000_0000_0000_FFFF;
        tick();
        release dut.seq_q;
        push(0, 64'h0000_0000_0000_1234, 1'b1);
        push(0, 64'h0000_0000_0000_5678, 1'b1);
        drive();
        run("wrap", 60);
        expq = '{hdr(0, 16'hFFFF), 64'h0000_0000_0000_1234, trl(0, 16'hFFFF, 1'b0, 16'd1),
                 hdr(0, 16'h0000), 64'h0000_0000_0000_5678, trl(0, 16'h0000, 1'b0, 16'd1)};
        cmp("wrap");

        // Round robin between ch1 and ch3, two 2-word packets each
        for (int k = 0; k < 4; k++) begin
            push(1, 64'hA100_0000_0000_0000 | 64'(k), k[0]);
            push(3, 64'hB300_0000_0000_0000 | 64'(k), k[0]);
        end
        drive();
        tick();
        tick();
        chk("rr active_ch", 64'(s_active), 64'd1);
        chk("rr busy", 64'(s_busy), 64'd1);
        chk("rr ready", 64'(s_ready), 64'b0010);
        run("rr", 100);
        expq = '{hdr(1, 0), 64'hA100_0000_0000_0000, 64'hA100_0000_0000_0001, trl(1, 0, 1'b0, 16'd2),
                 hdr(3, 0), 64'hB300_0000_0000_0000, 64'hB300_0000_0000_0001, trl(3, 0, 1'b0, 16'd2),
                 hdr(1, 1), 64'hA100_0000_0000_0002, 64'hA100_0000_0000_0003, trl(1, 1, 1'b0, 16'd2),
                 hdr(3, 1), 64'hB300_0000_0000_0002, 64'hB300_0000_0000_0003, trl(3, 1, 1'b0, 16'd2)};
        cmp("rr");

        // Back-pressure for 5 cycles with C1 in the hold register
        push(2, 64'hC0C0_0000_0000_0000, 1'b0);
        push(2, 64'hC1C1_0000_0000_0001, 1'b0);
        push(2, 64'hC2C2_0000_0000_0002, 1'b1);
        drive();
        repeat (3) tick();
        bus.wrfifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp wren %0d", k), 64'(s_wren), 64'd0);
            chk($sformatf("bp wrdata %0d", k), s_wrdata, 64'hC1C1_0000_0000_0001);
            chk($sformatf("bp ready %0d", k), 64'(s_ready), 64'd0);
        end
        bus.wrfifo_full = 1'b0;
        run("bp", 60);
        expq = '{hdr(2, 0), 64'hC0C0_0000_0000_0000, 64'hC1C1_0000_0000_0001,
                 64'hC2C2_0000_0000_0002, trl(2, 0, 1'b0, 16'd3)};
        cmp("bp");

        // Truncation at MAX_BURST=4 of a 6-word ch2 packet
        for (int k = 0; k < 6; k++) push(2, 64'hE200_0000_0000_0000 | 64'(k), k == 5);
        drive();
        run("trunc", 80);
        expq = '{hdr(2, 1), 64'hE200_0000_0000_0000, 64'hE200_0000_0000_0001,
                 64'hE200_0000_0000_0002, 64'hE200_0000_0000_0003, trl(2, 1, 1'b1, 16'd4),
                 hdr(2, 2), 64'hE200_0000_0000_0004, 64'hE200_0000_0000_0005, trl(2, 2, 1'b0, 16'd2)};
        cmp("trunc");

        // Reset during the second data word of a ch1 packet
        for (int k = 0; k < 4; k++) push(1, 64'hF100_0000_0000_0000 | 64'(k), k == 3);
        drive();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rst wren", 64'(bus.wren), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst wrdata", bus.wrdata, 64'd0);
        chk("rst ready", 64'(bus.req_ready), 64'd0);
        chk("rst active_ch", 64'(active_ch), 64'd0);
        for (int c = 0; c < 4; c++) chq[c].delete();
        outq.delete();
        outc.delete();
        drive();
        repeat (2) tick();
        rst_n = 1'b1;
        push(1, 64'h0000_0000_0000_0111, 1'b1);
        push(0, 64'h0000_0000_0000_0000, 1'b1);
        drive();
        run("post-reset", 60);
        expq = '{hdr(0, 0), 64'h0000_0000_0000_0000, trl(0, 0, 1'b0, 16'd1),
                 hdr(1, 0), 64'h0000_0000_0000_0111, trl(1, 0, 1'b0, 16'd1)};
        cmp("post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
